word_demux4_reg: RTL and testbench

//   Registered 1-to-4 word demultiplexer with valid/ready handshake on both sides.

---
 rtl/word_demux4_reg_pkg.sv | 20 ++
 rtl/word_demux4_reg_demux_slot.sv | 32 +++
 rtl/word_demux4_reg.sv | 53 +++++
 tb/tb_word_demux4_reg.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/word_demux4_reg_pkg.sv
// Shared widths and small routing helpers for the registered word demux.
// Channel numbers are plain 2-bit values; vectors use ascending [0:N] order.
package word_demux4_reg_pkg;

    localparam int WORD_W      = 16;
    localparam int DEMUX_SEL_W = 2;
    localparam int N_CHAN      = 4;

    function automatic logic mux4(input logic [0:3] d, input logic [1:0] s);
        return d[s];
    endfunction

    function automatic logic [0:3] dec2to4(input logic [1:0] s);
        logic [0:3] r;
        r    = '0;
        r[s] = 1'b1;
        return r;
    endfunction

endpackage

// File: rtl/word_demux4_reg_demux_slot.sv
// One-entry holding register for a single demux output channel.
// A load always wins over a drain so fill and drain can share a cycle.
import word_demux4_reg_pkg::*;

module demux_slot #(
    parameter int WIDTH = WORD_W
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_load,
    input  logic [0:WIDTH-1] i_val,
    input  logic             i_ready,
    output logic             o_valid,
    output logic [0:WIDTH-1] o_val,
    output logic             o_free
);

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            o_valid <= 1'b0;
            o_val   <= '0;
        end else if (i_load) begin
            o_valid <= 1'b1;
            o_val   <= i_val;
        end else if (o_valid & i_ready) begin
            o_valid <= 1'b0;
        end
    end

    assign o_free = !o_valid | i_ready;

endmodule

// File: rtl/word_demux4_reg.sv
// Registered 1-to-4 word demultiplexer with valid/ready on both sides.
// Each channel owns its own slot, so a stalled consumer only blocks its words.
import word_demux4_reg_pkg::*;

module word_demux4_reg #(
    parameter int WIDTH = WORD_W
) (
    input  logic                   i_clk,
    input  logic                   i_rst,
    input  logic                   i_valid,
    output logic                   o_ready,
    input  logic [0:DEMUX_SEL_W-1] i_sel,
    input  logic [0:WIDTH-1]       i_val,
    output logic [0:3]             o_valid,
    input  logic [0:3]             i_ready,
    output logic [0:WIDTH-1]       o_val0,
    output logic [0:WIDTH-1]       o_val1,
    output logic [0:WIDTH-1]       o_val2,
    output logic [0:WIDTH-1]       o_val3
);

    logic [1:0]       k;
    logic             acc;
    logic [0:3]       load;
    logic [0:3]       free;
    logic [0:WIDTH-1] slot_val [0:N_CHAN-1];

    assign k = {i_sel[0], i_sel[1]};

    // Ready is a pure function of the addressed slot, never of i_valid.
    assign o_ready = !i_rst & mux4(free, k);
    assign acc     = i_valid & o_ready;
    assign load    = dec2to4(k) & {4{acc}};

    for (genvar j = 0; j < N_CHAN; j++) begin : g_slot
        demux_slot #(.WIDTH(WIDTH)) u_slot (
            .i_clk   (i_clk),
            .i_rst   (i_rst),
            .i_load  (load[j]),
            .i_val   (i_val),
            .i_ready (i_ready[j]),
            .o_valid (o_valid[j]),
            .o_val   (slot_val[j]),
            .o_free  (free[j])
        );
    end

    assign o_val0 = slot_val[0];
    assign o_val1 = slot_val[1];
    assign o_val2 = slot_val[2];
    assign o_val3 = slot_val[3];

endmodule

// File: tb/tb_word_demux4_reg.sv
// Directed bench for word_demux4_reg with a per-channel slot model.
module tb_word_demux4_reg;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        o_ready;
    logic [0:1]  sel;
    logic [0:15] val;
    logic [0:3]  o_valid;
    logic [0:3]  rdy;
    logic [0:15] o_val0, o_val1, o_val2, o_val3;

    int checks = 0;
    int failures = 0;

    word_demux4_reg #(.WIDTH(16)) dut (
        .i_clk   (clk),
        .i_rst   (rst),
        .i_valid (in_valid),
        .o_ready (o_ready),
        .i_sel   (sel),
        .i_val   (val),
        .o_valid (o_valid),
        .i_ready (rdy),
        .o_val0  (o_val0),
        .o_val1  (o_val1),
        .o_val2  (o_val2),
        .o_val3  (o_val3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Model: one occupancy flag and one last-written word per channel.
    bit          m_full [4];
    logic [15:0] m_word [4];

    function automatic logic exp_ready();
        int c;
        c = int'(sel);
        return !rst && (!m_full[c] || rdy[c]);
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int j = 0; j < 4; j++) begin
                m_full[j] = 0;
                m_word[j] = 16'h0;
            end
        end else begin
            bit take;
            take = in_valid && exp_ready();
            for (int j = 0; j < 4; j++) begin
                if (take && int'(sel) == j) begin
                    m_full[j] = 1;
                    m_word[j] = val;
                end else if (m_full[j] && rdy[j]) begin
                    m_full[j] = 0;
                end
            end
        end
    end

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        chk("m_ready", 32'(o_ready), 32'(exp_ready()));
        chk("m_valid", 32'(o_valid),
            32'({m_full[0], m_full[1], m_full[2], m_full[3]}));
        chk("m_val0", 32'(o_val0), 32'(m_word[0]));
        chk("m_val1", 32'(o_val1), 32'(m_word[1]));
        chk("m_val2", 32'(o_val2), 32'(m_word[2]));
        chk("m_val3", 32'(o_val3), 32'(m_word[3]));
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [1:0] c, input logic [15:0] w);
        in_valid = 1'b1;
        sel      = c;
        val      = w;
    endtask

    initial begin
        rst      = 1'b1;
        in_valid = 1'b0;
        sel      = 2'd0;
        val      = 16'h0;
        rdy      = 4'b1111;
        step();
        @(negedge clk);
        chk("rst_valid", 32'(o_valid), 32'h0);
        chk("rst_ready", 32'(o_ready), 32'h0);
        chk("rst_val2", 32'(o_val2), 32'h0);
        step();
        rst = 1'b0;

        // 1: single word to channel 2
        send(2'd2, 16'hA5C3);
        @(negedge clk);
        chk("t1_ready", 32'(o_ready), 32'h1);
        step();
        in_valid = 1'b0;
        @(negedge clk);
        chk("t1_valid", 32'(o_valid), 32'b0010);
        chk("t1_val2", 32'(o_val2), 32'hA5C3);
        step();
        @(negedge clk);
        chk("t1_drain", 32'(o_valid), 32'h0);

        // 2: streaming one word per cycle over all channels
        for (int c = 0; c < 4; c++) begin
            send(2'(c), 16'(c + 1));
            step();
        end
        in_valid = 1'b0;
        @(negedge clk);
        chk("t2_valid", 32'(o_valid), 32'b0001);
        chk("t2_val3", 32'(o_val3), 32'h0004);
        chk("t2_val1", 32'(o_val1), 32'h0002);
        step();

        // 3: backpressure on channel 1
        rdy = 4'b1011;
        send(2'd1, 16'h1111);
        step();
        send(2'd1, 16'h2222);
        @(negedge clk);
        chk("t3_stall", 32'(o_ready), 32'h0);
        chk("t3_hold", 32'(o_val1), 32'h1111);
        step();
        rdy = 4'b1111;
        #1;
        chk("t3_comb", 32'(o_ready), 32'h1);
        step();
        in_valid = 1'b0;
        @(negedge clk);
        chk("t3_val1", 32'(o_val1), 32'h2222);
        chk("t3_valid", 32'(o_valid), 32'b0100);
        step();

        // 4: stalled channel 0 does not block channel 3
        rdy = 4'b0111;
        send(2'd0, 16'h0C0C);
        step();
        send(2'd3, 16'hBEEF);
        @(negedge clk);
        chk("t4_ready", 32'(o_ready), 32'h1);
        step();
        in_valid = 1'b0;
        @(negedge clk);
        chk("t4_val3", 32'(o_val3), 32'hBEEF);
        chk("t4_val0", 32'(o_val0), 32'h0C0C);
        chk("t4_valid", 32'(o_valid), 32'b1001);
        rdy = 4'b1111;
        step();

        // 5: drain and refill channel 2 in one cycle
        rdy = 4'b1101;
        send(2'd2, 16'h00FF);
        step();
        rdy = 4'b1111;
        send(2'd2, 16'hFF00);
        @(negedge clk);
        chk("t5_ready", 32'(o_ready), 32'h1);
        chk("t5_old", 32'(o_val2), 32'h00FF);
        step();
        in_valid = 1'b0;
        @(negedge clk);
        chk("t5_valid", 32'(o_valid), 32'b0010);
        chk("t5_val2", 32'(o_val2), 32'hFF00);
        step();

        // 6: async reset with all slots full
        rdy = 4'b0000;
        for (int c = 0; c < 4; c++) begin
            send(2'(c), 16'h5A00 + 16'(c));
            step();
        end
        in_valid = 1'b0;
        @(negedge clk);
        chk("t6_full", 32'(o_valid), 32'b1111);
        #2;
        rst = 1'b1;
        #1;
        chk("t6_valid", 32'(o_valid), 32'h0);
        chk("t6_ready", 32'(o_ready), 32'h0);
        chk("t6_vals", 32'({o_val0, o_val1} | {o_val2, o_val3}), 32'h0);
        step();
        rst = 1'b0;
        rdy = 4'b1111;
        @(negedge clk);
        chk("t6_rel_rdy", 32'(o_ready), 32'h1);
        chk("t6_rel_vld", 32'(o_valid), 32'h0);
        step();
        @(negedge clk);
        chk("t6_stale", 32'(o_valid), 32'h0);
        step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
